// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the UART TX arbiter and the feedback byte formats.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_SENDING,
    S_GAP
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_MAN  = 2'd1;
  localparam logic [1:0] GNT_SCR  = 2'd2;
  localparam logic [1:0] GNT_HB   = 2'd3;

  localparam logic [7:0] HB_BYTE_DEF = 8'h03;

  // Packet-type tags carried in the top bits of TX and RX bytes
  localparam logic [1:0] PKT_CMD      = 2'b00;
  localparam logic [1:0] PKT_SCRIPT   = 2'b01;
  localparam logic [1:0] PKT_STATUS   = 2'b10;
  localparam logic [1:0] PKT_FEEDBACK = 2'b11;

endpackage

// File: rtl/uart_tx_arbiter_hb_timer.sv
// Periodic status-query timer: raises hb_pend every HB_PERIOD cycles while enabled.
module hb_timer
  import uart_tx_arbiter_pkg::*;
#(
  parameter int HB_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic hb_en,
  input  logic hb_clr,
  output logic hb_pend
);

  localparam int CW = (HB_PERIOD > 2) ? $clog2(HB_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(HB_PERIOD - 1));

  // A wrap coinciding with a clear is a fresh query, so set wins
  always_ff @(posedge clk) begin
    if (rst || !hb_en) begin
      cnt     <= '0;
      hb_pend <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + CW'(1);
      hb_pend <= (hb_pend & ~hb_clr) | wrap;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX between manual, script and heartbeat sources,
// one byte at a time with a start/busy handshake and an enforced idle gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         GAP_CYCLES   = 16,
  parameter int         HB_PERIOD    = 100000,
  parameter logic [7:0] HB_BYTE      = HB_BYTE_DEF,
  parameter int         BUSY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       man_req,
  input  logic [7:0] man_data,
  output logic       man_ack,
  input  logic       scr_req,
  input  logic [7:0] scr_data,
  output logic       scr_ack,
  input  logic       hb_en,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [1:0] grant,
  output logic       tx_err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t        state;
  logic          rr_scr;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          hb_pend;
  logic          hb_clr;

  assign hb_clr = (state == S_LAUNCH) && (grant == GNT_HB);

  hb_timer #(.HB_PERIOD(HB_PERIOD)) u_hb (
    .clk     (clk),
    .rst     (rst),
    .hb_en   (hb_en),
    .hb_clr  (hb_clr),
    .hb_pend (hb_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      man_ack  <= 1'b0;
      scr_ack  <= 1'b0;
      tx_err   <= 1'b0;
      tx_data  <= 8'h00;
      grant    <= GNT_NONE;
      rr_scr   <= 1'b0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      man_ack  <= 1'b0;
      scr_ack  <= 1'b0;
      tx_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (hb_pend) begin
            tx_data  <= HB_BYTE;
            grant    <= GNT_HB;
            tx_start <= 1'b1;
            state    <= S_LAUNCH;
          end else if (man_req && (!scr_req || !rr_scr)) begin
            tx_data  <= man_data;
            grant    <= GNT_MAN;
            man_ack  <= 1'b1;
            tx_start <= 1'b1;
            rr_scr   <= 1'b1;
            state    <= S_LAUNCH;
          end else if (scr_req) begin
            tx_data  <= scr_data;
            grant    <= GNT_SCR;
            scr_ack  <= 1'b1;
            tx_start <= 1'b1;
            rr_scr   <= 1'b0;
            state    <= S_LAUNCH;
          end
        end
        // The launch cycle itself counts toward the busy timeout
        S_LAUNCH: begin
          tmo_cnt <= TW'(1);
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_SENDING;
          end else if (tmo_cnt >= TW'(BUSY_TIMEOUT - 1)) begin
            tx_err  <= 1'b1;
            grant   <= GNT_NONE;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_SENDING: begin
          if (!tx_busy) begin
            grant   <= GNT_NONE;
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= S_IDLE;
          else                                gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART TX busy model.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       man_req = 1'b0, scr_req = 1'b0, hb_en = 1'b0, tx_busy = 1'b0;
  logic [7:0] man_data = 8'h00, scr_data = 8'h00;
  logic       man_ack, scr_ack, tx_start, tx_err;
  logic [7:0] tx_data;
  logic [1:0] grant;

  uart_tx_arbiter #(
    .GAP_CYCLES(16), .HB_PERIOD(50), .HB_BYTE(8'h03), .BUSY_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .man_req(man_req), .man_data(man_data), .man_ack(man_ack),
    .scr_req(scr_req), .scr_data(scr_data), .scr_ack(scr_ack),
    .hb_en(hb_en), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int bs = -100;
  bit busy_on = 1'b1;

  // TX model: busy for 10 cycles starting 2 cycles after tx_start
  always @(posedge clk) begin
    cyc++;
    #1;
    tx_busy = busy_on && (cyc >= bs) && (cyc < bs + 10);
  end

  logic [7:0] st_data[$];
  int         st_cyc[$];
  logic [1:0] st_gnt[$];
  int         err_cyc[$];
  int         n_mack = 0, n_sack = 0, n_bad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        st_data.push_back(tx_data);
        st_cyc.push_back(cyc);
        st_gnt.push_back(grant);
        bs = cyc + 2;
      end
      if (man_ack) n_mack++;
      if (scr_ack) n_sack++;
      if ((man_ack || scr_ack) && !tx_start) n_bad++;
      if (man_ack && scr_ack) n_bad++;
      if (tx_err) err_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    st_data.delete(); st_cyc.delete(); st_gnt.delete(); err_cyc.delete();
    n_mack = 0; n_sack = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; man_req = 1'b0; scr_req = 1'b0; hb_en = 1'b0;
    busy_on = 1'b1; bs = -100;
    repeat (3) @(posedge clk);
    #1;
    clr_log();
    rst = 1'b0;
  endtask

  task automatic wait_n(input int n, input int budget, input string tag);
    int k = 0;
    while (st_data.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(tag, int'(st_data.size() >= n), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_acks", int'({man_ack, scr_ack}), 0);
    chk("rst_tx_err", int'(tx_err), 0);
    chk("rst_tx_data", int'(tx_data), 'h00);
    chk("rst_grant", int'(grant), 0);

    // Single manual byte, held for a second byte to measure spacing
    do_reset();
    idle(1);
    t = cyc; man_data = 8'hA5; man_req = 1'b1;
    wait_n(1, 10, "t1_start");
    chk("t1_latency", st_cyc[0], t + 1);
    chk("t1_data", int'(st_data[0]), 'hA5);
    chk("t1_grant", int'(st_gnt[0]), 1);
    chk("t1_ack", n_mack, 1);
    wait_n(2, 60, "t1_start2");
    #1 man_req = 1'b0;
    chk("t1_spacing", st_cyc[1] - st_cyc[0], 30);
    chk("t1_gap_min", int'((st_cyc[1] - (st_cyc[0] + 12)) >= 16), 1);
    idle(40);
    chk("t1_acks", n_mack, 2);
    chk("t1_scr_acks", n_sack, 0);

    // Round robin with both sources held
    do_reset();
    man_data = 8'h11; scr_data = 8'h22; man_req = 1'b1; scr_req = 1'b1;
    wait_n(4, 200, "t2_starts");
    #1 man_req = 1'b0; scr_req = 1'b0;
    chk("t2_b0", int'(st_data[0]), 'h11);
    chk("t2_b1", int'(st_data[1]), 'h22);
    chk("t2_b2", int'(st_data[2]), 'h11);
    chk("t2_b3", int'(st_data[3]), 'h22);
    chk("t2_man_acks", n_mack, 2);
    chk("t2_scr_acks", n_sack, 2);
    idle(40);

    // Periodic heartbeat
    do_reset();
    hb_en = 1'b1;
    wait_n(3, 250, "t3_starts");
    #1 hb_en = 1'b0;
    chk("t3_data0", int'(st_data[0]), 'h03);
    chk("t3_data2", int'(st_data[2]), 'h03);
    chk("t3_grant", int'(st_gnt[1]), 3);
    chk("t3_period1", st_cyc[1] - st_cyc[0], 50);
    chk("t3_period2", st_cyc[2] - st_cyc[1], 50);
    chk("t3_no_acks", n_mack + n_sack, 0);
    idle(40);

    // Heartbeat preempts a continuously requesting script
    do_reset();
    hb_en = 1'b1; scr_data = 8'h22; scr_req = 1'b1;
    wait_n(4, 250, "t4_starts");
    #1 scr_req = 1'b0; hb_en = 1'b0;
    chk("t4_b0", int'(st_data[0]), 'h22);
    chk("t4_b1", int'(st_data[1]), 'h22);
    chk("t4_b2_hb", int'(st_data[2]), 'h03);
    chk("t4_b3", int'(st_data[3]), 'h22);
    idle(40);

    // Busy never rises: timeout error, then next byte still served
    do_reset();
    busy_on = 1'b0; man_data = 8'hA5; man_req = 1'b1;
    wait_n(1, 10, "t5_start1");
    #1 man_req = 1'b0; scr_data = 8'h22; scr_req = 1'b1;
    wait_n(2, 60, "t5_start2");
    #1 scr_req = 1'b0;
    chk("t5_err_cnt", err_cyc.size(), 1);
    chk("t5_err_delay", err_cyc[0] - st_cyc[0], 4);
    chk("t5_next_delay", st_cyc[1] - st_cyc[0], 21);
    chk("t5_next_data", int'(st_data[1]), 'h22);
    idle(40);

    // Reset mid-frame clears outputs and the round-robin pointer
    do_reset();
    man_data = 8'hA5; man_req = 1'b1;
    wait_n(1, 10, "t6_start");
    #1 man_req = 1'b0;
    idle(2);
    chk("t6_sending_grant", int'(grant), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_outs", int'({tx_start, man_ack, scr_ack, tx_err}), 0);
    chk("t6_data", int'(tx_data), 0);
    chk("t6_grant", int'(grant), 0);
    for (int k = 0; k < 30 && tx_busy; k++) @(posedge clk);
    @(posedge clk); #1;
    clr_log();
    rst = 1'b0;
    man_data = 8'h11; scr_data = 8'h22; man_req = 1'b1; scr_req = 1'b1;
    wait_n(2, 100, "t6_starts");
    #1 man_req = 1'b0; scr_req = 1'b0;
    chk("t6_first_man", int'(st_data[0]), 'h11);
    chk("t6_second_scr", int'(st_data[1]), 'h22);
    idle(40);

    // Manual request withdrawn before being granted
    do_reset();
    scr_data = 8'h22; scr_req = 1'b1;
    wait_n(1, 10, "t7_start1");
    #1 man_data = 8'h11; man_req = 1'b1;
    idle(5);
    man_req = 1'b0;
    wait_n(2, 60, "t7_start2");
    #1 scr_req = 1'b0;
    idle(40);
    chk("t7_bytes", st_data.size(), 2);
    chk("t7_b1", int'(st_data[1]), 'h22);
    chk("t7_man_acks", n_mack, 0);
    chk("t7_scr_acks", n_sack, 2);

    chk("ack_outside_launch", n_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
